shifter_ctrl: RTL and testbench
===============================

SHIFTER_CTRL -- requirements
Module: shifter_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 10: width of the frame-length field and the sample counter.
REQ-002 SHALL have parameter FLUSH_CYC, default 1, range 1..4: downstream shifter pipeline latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_neg, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled every cycle.
REQ-006 SHALL have port bypass_mode, input, 1 bit: bypass the shifter for the frame, latched when start is accepted.
REQ-007 SHALL have port frame_len, input, LEN_W bits: samples in the frame, latched when start is accepted; 0 is illegal.
REQ-008 SHALL have port in_valid, input, 1 bit: strobe for the current IF sample.
REQ-009 SHALL have port abort, input, 1 bit: cancels the frame in progress.
REQ-010 SHALL have port shf_en, output, 1 bit: the shifter consumes a sample this cycle.
REQ-011 SHALL have port shf_bypass, output, 1 bit: bypass select to the shifter.
REQ-012 SHALL have port phase, output, 3 bits: 45-degree rotation index for the current sample.
REQ-013 SHALL have port out_valid, output, 1 bit: the shifter output is valid this cycle.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-016 SHALL have port err, output, 1 bit: sticky illegal-request flag.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH and DONE.
REQ-018 In IDLE, start=1 with frame_len!=0 and abort=0 SHALL:
- latch frame_len and bypass_mode;
- clear phase, the sample counter and err;
- enter RUN on the next cycle.
REQ-019 In IDLE, start=1 with frame_len==0 SHALL set err=1 and stay in IDLE.
REQ-020 start=1 in any state other than IDLE SHALL be ignored and SHALL set err=1; the frame in progress is unaffected.
REQ-021 shf_en SHALL equal (state==RUN && in_valid), combinationally.
REQ-022 On each cycle with shf_en=1, phase SHALL advance by 1 modulo 8 (7 wraps to 0) and the sample counter SHALL increment.
REQ-023 phase SHALL be held at 0 throughout a frame latched with bypass_mode=1.
REQ-024 shf_bypass SHALL equal the latched bypass bit while busy=1, and 0 in IDLE.
REQ-025 With in_valid=0 in RUN, the state, phase and counter SHALL hold.
REQ-026 shf_en=1 while counter==len-1 SHALL move the state to FLUSH on the next cycle; no other condition ends RUN except abort.
REQ-027 FLUSH SHALL last exactly FLUSH_CYC cycles, then go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-029 out_valid SHALL be shf_en delayed by FLUSH_CYC cycles through a shift register.
REQ-030 abort=1 in RUN, FLUSH or DONE SHALL:
- force IDLE on the next cycle;
- suppress done;
- clear the out_valid pipeline;
- leave err unchanged.
REQ-031 When abort and start are both high in IDLE, abort SHALL take priority and start SHALL be ignored, with no err update.
REQ-032 Counter arithmetic SHALL be unsigned LEN_W bits; a frame length of 2^LEN_W-1 SHALL complete without overflow.

Reset
REQ-033 rst_neg=0 SHALL asynchronously force the following, with no completion pulse:
- state=IDLE;
- phase, counter, latched length and latched bypass to 0;
- the out_valid pipeline to 0;
- shf_en, shf_bypass, out_valid, busy, done and err to 0.
REQ-034 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL accept a new start on the first clock edge.

Verification
REQ-035 Scenario: start at cycle 0 with len=4, bypass=0, in_valid continuous, FLUSH_CYC=1.
- Required: shf_en on cycles 1-4 with phase 0,1,2,3; out_valid on cycles 2-5; FLUSH on cycle 5; done=1 on cycle 6 only; busy on cycles 1-6.
REQ-036 Scenario: len=10 with in_valid toggling every other cycle.
- Required: phase sequence 0..7,0,1; hold while in_valid=0; exactly 10 shf_en pulses, then done.
REQ-037 Scenario: bypass_mode=1 with len=3.
- Required: shf_bypass=1 while busy; phase=0 on every sample; 3 out_valid pulses; done.
REQ-038 Scenario: start with len=0.
- Required: err=1 and busy=0; a following start with len=2 clears err and completes normally.
REQ-039 Scenario: abort after 2 samples of len=8.
- Required: IDLE on the next cycle; no done; out_valid=0 from that cycle on; a new start is accepted.
REQ-040 Scenario: start while busy, then rst_neg pulsed mid-RUN.
- Required: err=1 with the frame continuing unchanged; after the reset all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shifter_ctrl.sv
// ---------------------------------------------------------------------------
// shifter_ctrl
//   Frame sequencer for a 45-degree-step phase shifter. Accepts a frame
//   request, steps the rotation index once per valid input sample, waits for
//   the shifter pipeline to drain, then pulses done.
//
// Ports
//   clk          rising-edge clock
//   rst_neg      asynchronous active-low reset
//   start        frame request (sampled every cycle)
//   bypass_mode  bypass the shifter for this frame (latched on start)
//   frame_len    samples in the frame, LEN_W bits (latched on start, 0 illegal)
//   in_valid     current IF sample strobe
//   abort        cancel the frame in progress
//   shf_en       shifter consumes a sample this cycle
//   shf_bypass   bypass select to the shifter
//   phase        3-bit rotation index for the current sample
//   out_valid    shifter output valid (shf_en delayed FLUSH_CYC cycles)
//   busy         state is not IDLE
//   done         one-cycle frame-complete pulse
//   err          sticky illegal-request flag
// ---------------------------------------------------------------------------
module shifter_ctrl #(
    parameter int LEN_W     = 10,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_neg,
    input  logic             start,
    input  logic             bypass_mode,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic             abort,
    output logic             shf_en,
    output logic             shf_bypass,
    output logic [2:0]       phase,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic                 r_bypass;
    logic [2:0]           r_phase;
    logic [2:0]           r_fcnt;
    logic                 r_err;
    logic [FLUSH_CYC-1:0] r_vld_pipe;

    logic w_shf_en;
    logic w_busy;
    logic w_last;

    assign w_shf_en = (r_state == S_RUN) && in_valid;
    assign w_busy   = (r_state != S_IDLE);
    // Compare against len-1 rather than cnt+1==len so a length of
    // 2^LEN_W-1 never needs a wider counter.
    assign w_last   = (r_cnt == (r_len - LEN_W'(1)));

    assign shf_en     = w_shf_en;
    assign shf_bypass = w_busy && r_bypass;
    assign phase      = r_phase;
    assign out_valid  = r_vld_pipe[FLUSH_CYC-1];
    assign busy       = w_busy;
    // An abort landing in the DONE cycle cancels the completion pulse.
    assign done       = (r_state == S_DONE) && !abort;
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_bypass   <= 1'b0;
            r_phase    <= 3'd0;
            r_fcnt     <= 3'd0;
            r_err      <= 1'b0;
            r_vld_pipe <= '0;
        end else begin
            // out_valid delay line; an abort flushes anything in flight.
            if (abort && w_busy) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_shf_en;
                for (int i = 1; i < FLUSH_CYC; i++)
                    r_vld_pipe[i] <= r_vld_pipe[i-1];
            end

            // A request while a frame is active is flagged but otherwise ignored.
            if (start && w_busy)
                r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    // abort has priority over start in IDLE and leaves err alone.
                    if (start && !abort) begin
                        if (frame_len == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_len    <= frame_len;
                            r_bypass <= bypass_mode;
                            r_phase  <= 3'd0;
                            r_cnt    <= '0;
                            r_err    <= 1'b0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_shf_en) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        // Bypassed frames keep the rotation index pinned at 0.
                        if (!r_bypass)
                            r_phase <= r_phase + 3'd1;
                        if (w_last) begin
                            r_fcnt  <= 3'd0;
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (abort)
                        r_state <= S_IDLE;
                    else if (r_fcnt == FLUSH_LAST)
                        r_state <= S_DONE;
                    else
                        r_fcnt <= r_fcnt + 3'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shifter_ctrl
//   Directed bench for shifter_ctrl (LEN_W=10, FLUSH_CYC=1). A vector table
//   covers the basic frame, bypass, zero-length and busy-start cases; hand
//   sequences cover gapped input, abort, mid-frame reset and maximum length.
// ---------------------------------------------------------------------------
module tb_shifter_ctrl;

    localparam int LEN_W     = 10;
    localparam int FLUSH_CYC = 1;

    logic             clk = 1'b0;
    logic             rst_neg = 1'b0;
    logic             start = 1'b0;
    logic             bypass_mode = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             in_valid = 1'b0;
    logic             abort = 1'b0;
    logic             shf_en, shf_bypass, out_valid, busy, done, err;
    logic [2:0]       phase;

    shifter_ctrl #(.LEN_W(LEN_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk        (clk),
        .rst_neg    (rst_neg),
        .start      (start),
        .bypass_mode(bypass_mode),
        .frame_len  (frame_len),
        .in_valid   (in_valid),
        .abort      (abort),
        .shf_en     (shf_en),
        .shf_bypass (shf_bypass),
        .phase      (phase),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {shf_en, phase[2:0], out_valid, busy, done, err, shf_bypass}
    function automatic logic [8:0] outs();
        return {shf_en, phase, out_valid, busy, done, err, shf_bypass};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic st, input logic byp, input logic [LEN_W-1:0] len,
                         input logic iv, input logic ab);
        @(negedge clk);
        start = st; bypass_mode = byp; frame_len = len; in_valid = iv; abort = ab;
        #1;
    endtask

    typedef struct {
        logic             st;
        logic             byp;
        logic [LEN_W-1:0] len;
        logic             iv;
        logic             ab;
        logic [8:0]       exp;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic st, input logic byp, input int len,
                                input logic iv, input logic ab,
                                input logic en, input int ph, input logic ov,
                                input logic bsy, input logic dn, input logic er,
                                input logic sb);
        vec_t v;
        v.st = st; v.byp = byp; v.len = LEN_W'(len); v.iv = iv; v.ab = ab;
        v.exp = {en, 3'(ph), ov, bsy, dn, er, sb};
        return v;
    endfunction

    initial begin
        int  cnt, ov_cnt;
        logic seen_done;
        logic bad;

        //           st byp len iv ab | en ph ov bsy dn er sb
        // len=4, continuous input
        tbl[0]  = mk(1, 0, 4, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0,   1, 1, 1, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0,   1, 2, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0,   1, 3, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 0,   0, 4, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0,   0, 4, 0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0,   0, 4, 0, 0, 0, 0, 0);
        // bypass, len=3
        tbl[8]  = mk(1, 1, 3, 1, 0,   0, 4, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 0,   1, 0, 1, 1, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 1, 0,   1, 0, 1, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 0, 1);
        tbl[14] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        // len=0 is rejected, then len=2 clears err; start while busy re-flags it
        tbl[15] = mk(1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(1, 0, 2, 1, 0,   0, 0, 0, 0, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0);
        tbl[19] = mk(1, 0, 5, 1, 0,   1, 1, 1, 1, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 0,   0, 2, 1, 1, 0, 1, 0);
        tbl[21] = mk(0, 0, 0, 1, 0,   0, 2, 0, 1, 1, 1, 0);
        tbl[22] = mk(0, 0, 0, 1, 0,   0, 2, 0, 0, 0, 1, 0);
        // abort + start in IDLE: start ignored, err untouched
        tbl[23] = mk(1, 0, 3, 1, 1,   0, 2, 0, 0, 0, 1, 0);
        tbl[24] = mk(0, 0, 0, 1, 0,   0, 2, 0, 0, 0, 1, 0);

        // Reset state
        #2;
        chk("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_neg = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].st, tbl[i].byp, tbl[i].len, tbl[i].iv, tbl[i].ab);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // len=10 with in_valid on every other cycle
        drive(1, 0, 10, 0, 0);
        cnt = 0; ov_cnt = 0; seen_done = 1'b0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            drive(0, 0, 0, (k % 2 == 0), 0);
            if (out_valid) ov_cnt++;
            if (done) seen_done = 1'b1;
            if (cnt < 10) begin
                chk($sformatf("gap_en%0d", k), 32'(shf_en), 32'(k % 2 == 0));
                chk($sformatf("gap_ph%0d", k), 32'(phase), 32'(cnt % 8));
            end
            if (shf_en) cnt++;
        end
        chk("gap_pulses", 32'(cnt), 32'd10);
        chk("gap_ov_pulses", 32'(ov_cnt), 32'd10);
        chk("gap_done", 32'(seen_done), 32'd1);
        chk("gap_err_clear", 32'(err), 32'd0);

        // abort after two samples of len=8 (third sample in the abort cycle)
        drive(1, 0, 8, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        chk("abort_cycle_en", 32'(shf_en), 32'd1);
        drive(0, 0, 0, 1, 0);
        chk("abort_idle", 32'({busy, shf_en, out_valid, done}), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0);
            if (done || out_valid || busy) bad = 1'b1;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        drive(1, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("abort_restart", 32'({busy, shf_en, phase}), 32'({1'b1, 1'b1, 3'd0}));
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("abort_restart_done", 32'(done), 32'd1);
        drive(0, 0, 0, 1, 0);

        // start while busy, then reset mid-RUN
        drive(1, 0, 20, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 2, 1, 0);
        chk("busy_start_ph", 32'(phase), 32'd3);
        drive(0, 0, 0, 1, 0);
        chk("busy_start_state", 32'({err, busy, shf_en, phase}),
            32'({1'b1, 1'b1, 1'b1, 3'd4}));
        #2;
        rst_neg = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_neg = 1'b1;
        start = 1'b1; frame_len = LEN_W'(1); in_valid = 1'b1; bypass_mode = 1'b0;
        #1;
        drive(0, 0, 0, 1, 0);
        chk("post_reset_start", 32'({busy, shf_en}), 32'd3);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        // maximum length 2^LEN_W-1
        drive(1, 0, (1 << LEN_W) - 1, 1, 0);
        cnt = 0; seen_done = 1'b0;
        for (int k = 0; k < 1100 && !seen_done; k++) begin
            drive(0, 0, 0, 1, 0);
            if (shf_en) cnt++;
            if (done) seen_done = 1'b1;
        end
        chk("maxlen_pulses", 32'(cnt), 32'((1 << LEN_W) - 1));
        chk("maxlen_done", 32'(seen_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
